spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave with synchronized inputs, byte-wise tx/rx
// handshakes and a sticky overrun flag.
// Optional feature: define SPI_SLAVE_RX_FIFO_EN to buffer received bytes in a
// 4-entry FIFO instead of a single holding register.

module spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk,
   input  logic       spi_en,
   input  logic       spi_mosi,
   output logic       spi_miso,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overrun,
   input  logic       overrun_clr,
   output logic       busy
);

   // Edges are only trusted once the synchronizer chains have been refilled
   // from the pins after reset plus one cycle for the edge-history flops.
   // This keeps an spi_en that is already high at reset release from looking
   // like a fresh select.
   localparam logic [2:0] SETTLE_CNT = 3'(SYNC_STAGES + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                 state_r;
   state_t                 state_nxt_s;

   logic [SYNC_STAGES-1:0] clk_sync_r;
   logic [SYNC_STAGES-1:0] en_sync_r;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic                   clk_prev_r;
   logic                   en_prev_r;
   logic [2:0]             settle_r;

   logic                   settled_s;
   logic                   clk_s;
   logic                   en_s;
   logic                   mosi_s;
   logic                   clk_rise_s;
   logic                   clk_fall_s;
   logic                   en_rise_s;
   logic                   en_fall_s;

   logic [7:0]             tx_shift_r;
   logic [7:0]             tx_shift_nxt_s;
   logic [7:0]             rx_shift_r;
   logic [7:0]             rx_byte_s;
   logic [2:0]             bit_cnt_r;
   logic                   keep_r;
   logic                   miso_r;
   logic                   overrun_r;

   logic                   load_s;
   logic                   shift_in_s;
   logic                   shift_out_s;
   logic                   complete_s;
   logic                   full_s;
   logic                   pop_s;
   logic                   drop_s;
   logic                   push_s;

   // Input synchronizer chains for the three master-driven pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_r  <= '0;
         en_sync_r   <= '0;
         mosi_sync_r <= '0;
      end else begin
         clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], spi_clk};
         en_sync_r   <= {en_sync_r[SYNC_STAGES-2:0], spi_en};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   // Edge history of the synchronized copies and the post-reset settle count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_prev_r <= 1'b0;
         en_prev_r  <= 1'b0;
         settle_r   <= 3'd0;
      end else begin
         clk_prev_r <= clk_s;
         en_prev_r  <= en_s;
         if (settle_r != SETTLE_CNT) begin
            settle_r <= settle_r + 3'd1;
         end else begin
            settle_r <= settle_r;
         end
      end
   end

   assign clk_s      = clk_sync_r[SYNC_STAGES-1];
   assign en_s       = en_sync_r[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
   assign settled_s  = (settle_r == SETTLE_CNT);
   assign clk_rise_s = settled_s &  clk_s & ~clk_prev_r;
   assign clk_fall_s = settled_s & ~clk_s &  clk_prev_r;
   assign en_rise_s  = settled_s &  en_s  & ~en_prev_r;
   assign en_fall_s  = settled_s & ~en_s  &  en_prev_r;

   // Byte as it stands after the current rising edge's sample is shifted in.
   assign rx_byte_s  = {rx_shift_r[6:0], mosi_s};

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state plus the per-cycle shift/load/completion strobes.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      shift_in_s  = 1'b0;
      shift_out_s = 1'b0;
      complete_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (en_rise_s) begin
               state_nxt_s = SHIFT;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (en_fall_s) begin
               // A partial byte is simply abandoned: no push, no flag.
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SHIFT;
               if (clk_rise_s) begin
                  shift_in_s = 1'b1;
                  if (bit_cnt_r == 3'd7) begin
                     complete_s = 1'b1;
                     load_s     = 1'b1;
                  end else begin
                     complete_s = 1'b0;
                  end
               end else if (clk_fall_s) begin
                  // The fall right after a completion must not disturb the
                  // freshly loaded byte's MSB already on spi_miso.
                  shift_out_s = ~keep_r;
               end else begin
                  shift_out_s = 1'b0;
               end
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Next content of the tx shift register.
   always_comb begin
      tx_shift_nxt_s = tx_shift_r;
      if (load_s) begin
         tx_shift_nxt_s = tx_valid ? tx_data : 8'h00;
      end else if (shift_out_s) begin
         tx_shift_nxt_s = {tx_shift_r[6:0], 1'b0};
      end else begin
         tx_shift_nxt_s = tx_shift_r;
      end
   end

   // Shift registers, bit counter, keep flag and the registered miso pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shift_r <= 8'h00;
         rx_shift_r <= 8'h00;
         bit_cnt_r  <= 3'd0;
         keep_r     <= 1'b0;
         miso_r     <= 1'b0;
      end else begin
         tx_shift_r <= tx_shift_nxt_s;
         miso_r     <= (state_nxt_s == SHIFT) ? tx_shift_nxt_s[7] : 1'b0;
         if (shift_in_s) begin
            rx_shift_r <= rx_byte_s;
         end
         if ((state_r == IDLE) || en_fall_s) begin
            bit_cnt_r <= 3'd0;
         end else if (shift_in_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
         end
         if (complete_s) begin
            keep_r <= 1'b1;
         end else if (clk_fall_s || (state_r == IDLE)) begin
            keep_r <= 1'b0;
         end
      end
   end

   // A completion is dropped only when storage is full and nothing leaves it
   // in the same cycle.
   assign drop_s = complete_s & full_s & ~pop_s;
   assign push_s = complete_s & ~drop_s;

   // Sticky overrun; a new drop wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end else if (overrun_clr) begin
         overrun_r <= 1'b0;
      end
   end

`ifdef SPI_SLAVE_RX_FIFO_EN
   logic [7:0] fifo_mem_r [4];
   logic [1:0] wr_ptr_r;
   logic [1:0] rd_ptr_r;
   logic [2:0] count_r;

   assign full_s   = (count_r == 3'd4);
   assign rx_valid = (count_r != 3'd0);
   assign pop_s    = rx_valid & rx_ready;
   assign rx_data  = fifo_mem_r[rd_ptr_r];

   // Receive FIFO: a push into a full FIFO that is popped in the same cycle
   // writes the slot the head is leaving, which becomes the new tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            fifo_mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= 2'd0;
         rd_ptr_r <= 2'd0;
         count_r  <= 3'd0;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= rx_byte_s;
            wr_ptr_r             <= wr_ptr_r + 2'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
      end
   end
`else
   logic [7:0] hold_r;
   logic       hold_valid_r;

   assign full_s   = hold_valid_r;
   assign rx_valid = hold_valid_r;
   assign pop_s    = hold_valid_r & rx_ready;
   assign rx_data  = hold_r;

   // Single receive holding register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_r       <= 8'h00;
         hold_valid_r <= 1'b0;
      end else if (push_s) begin
         hold_r       <= rx_byte_s;
         hold_valid_r <= 1'b1;
      end else if (pop_s) begin
         hold_valid_r <= 1'b0;
      end
   end
`endif

   // tx_ready is decoded from flops only, so it is clean for the whole cycle
   // in which tx_data is taken.
   assign tx_ready = load_s;
   assign spi_miso = miso_r;
   assign overrun  = overrun_r;
   assign busy     = (state_r == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master plus a byte-level receive model that is
// compared against the DUT on every quiet cycle.

module tb_spi_slave;

   localparam int HALF   = 8;
   localparam int SETUP  = 10;
   localparam int SETTLE = 12;
`ifdef SPI_SLAVE_RX_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_clk;
   logic       spi_en;
   logic       spi_mosi;
   logic       spi_miso;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       overrun;
   logic       overrun_clr;
   logic       busy;

   int         n_checks = 0;
   int         n_errors = 0;
   logic       check_en = 1'b0;
   logic       drain_m  = 1'b0;
   logic       ov_m     = 1'b0;
   logic [7:0] mq[$];
   logic [7:0] exp_log[$];
   logic [7:0] rx_log[$];
   logic [7:0] tx_q[$];
   logic [39:0] got;

   spi_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
      .overrun_clr(overrun_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model of a completed byte: drained straight to the consumer, stored, or dropped.
   function automatic void model_complete(input logic [7:0] b);
      if (drain_m) exp_log.push_back(b);
      else if (mq.size() < CAP) mq.push_back(b);
      else ov_m = 1'b1;
   endfunction

   // Per-cycle comparison whenever the bus is quiet.
   initial begin
      forever begin
         @(negedge clk);
         if (check_en) begin
            chk("cyc_rx_valid", rx_valid, (mq.size() > 0));
            if (mq.size() > 0) chk("cyc_rx_data", rx_data, mq[0]);
            chk("cyc_overrun", overrun, ov_m);
            chk("cyc_busy", busy, 1'b0);
            chk("cyc_miso", spi_miso, 1'b0);
            chk("cyc_tx_ready", tx_ready, 1'b0);
         end
      end
   end

   // Record every byte the consumer accepts.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1 && rx_ready === 1'b1) rx_log.push_back(rx_data);
      end
   end

   // Producer: offers the head of tx_q and retires it when tx_ready is seen.
   initial begin
      logic take;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      forever begin
         @(negedge clk);
         take = tx_ready;
         @(posedge clk);
         #1;
         if (take && tx_q.size() > 0) void'(tx_q.pop_front());
         tx_valid = (tx_q.size() > 0);
         tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic frame(input int nbits, input logic [39:0] mosi_bits,
                        input logic drain, output logic [39:0] miso_bits);
      logic [7:0] b;
      miso_bits = '0;
      check_en  = 1'b0;
      drain_m   = drain;
      rx_ready  = drain;
      repeat (2) @(posedge clk);
      #1 spi_en = 1'b1;
      repeat (SETUP) @(posedge clk);
      #1;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mosi_bits[39-i];
         repeat (HALF) @(posedge clk);
         #1 spi_clk = 1'b1;
         miso_bits[39-i] = spi_miso;
         if (i % 8 == 7) begin
            b = mosi_bits[39 - 8*(i/8) -: 8];
            model_complete(b);
         end
         repeat (HALF) @(posedge clk);
         #1 spi_clk = 1'b0;
      end
      repeat (HALF) @(posedge clk);
      #1;
      spi_en   = 1'b0;
      spi_mosi = 1'b0;
      repeat (SETTLE) @(posedge clk);
      #1;
      rx_ready = 1'b0;
      drain_m  = 1'b0;
      check_en = 1'b1;
   endtask

   task automatic pop_rx();
      @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic clr_ovr();
      @(posedge clk);
      #1 overrun_clr = 1'b1;
      @(posedge clk);
      #1 overrun_clr = 1'b0;
      ov_m = 1'b0;
   endtask

   task automatic bit_toggle(input logic b);
      spi_mosi = b;
      repeat (HALF) @(posedge clk);
      #1 spi_clk = 1'b1;
      repeat (HALF) @(posedge clk);
      #1 spi_clk = 1'b0;
   endtask

   initial begin
      rst = 1'b1; spi_clk = 1'b0; spi_en = 1'b0; spi_mosi = 1'b0;
      rx_ready = 1'b0; overrun_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_miso", spi_miso, 1'b0);
      chk("rst_tx_ready", tx_ready, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (SETTLE) @(posedge clk);
      #1 check_en = 1'b1;

      // Single byte each way.
      tx_q.push_back(8'h3C);
      frame(8, {8'hA5, 32'h0}, 1'b0, got);
      chk("a5_rx_valid", rx_valid, 1'b1);
      chk("a5_rx_data", rx_data, 8'hA5);
      chk("a5_master_rx", got[39:32], 8'h3C);
      pop_rx();

      // Two back-to-back bytes under one select, consumer draining.
      rx_log.delete();
      exp_log.delete();
      tx_q.push_back(8'h56);
      tx_q.push_back(8'h78);
      frame(16, {8'h12, 8'h34, 24'h0}, 1'b1, got);
      chk("b2b_master_rx", got[39:24], 16'h5678);
      chk("b2b_rx_count", rx_log.size(), exp_log.size());
      if (rx_log.size() == 2) begin
         chk("b2b_rx0", rx_log[0], 8'h12);
         chk("b2b_rx1", rx_log[1], 8'h34);
      end
      for (int k = 0; k < rx_log.size() && k < exp_log.size(); k++)
         chk("b2b_rx_model", rx_log[k], exp_log[k]);

      // No tx data available: master reads zeros.
      tx_q.delete();
      frame(8, {8'h5A, 32'h0}, 1'b0, got);
      chk("novalid_master_rx", got[39:32], 8'h00);
      chk("novalid_rx_data", rx_data, 8'h5A);
      pop_rx();

      // Partial byte is discarded.
      frame(5, {8'hF0, 32'h0}, 1'b0, got);
      chk("partial_rx_valid", rx_valid, 1'b0);
      chk("partial_busy", busy, 1'b0);
      chk("partial_overrun", overrun, 1'b0);

      // Overrun: one byte more than storage holds.
      frame(8 * (CAP + 1), {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 1'b0, got);
      chk("ovr_flag", overrun, 1'b1);
      chk("ovr_first_kept", rx_data, 8'h11);
      chk("ovr_master_rx", got, 40'h0);
      clr_ovr();
      chk("ovr_cleared", overrun, 1'b0);
      for (int k = 0; k < CAP - 1; k++) pop_rx();

      // Reset pulsed mid-byte with select held high.
      check_en = 1'b0;
      #1 spi_en = 1'b1;
      repeat (SETUP) @(posedge clk);
      #1;
      bit_toggle(1'b1);
      bit_toggle(1'b1);
      bit_toggle(1'b0);
      chk("mid_busy_before", busy, 1'b1);
      rst = 1'b1;
      mq.delete();
      ov_m = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_miso", spi_miso, 1'b0);
      chk("mid_rst_tx_ready", tx_ready, 1'b0);
      chk("mid_rst_rx_data", rx_data, 8'h00);
      chk("mid_rst_rx_valid", rx_valid, 1'b0);
      chk("mid_rst_overrun", overrun, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) bit_toggle(1'b0);
      chk("mid_stay_idle", busy, 1'b0);
      chk("mid_no_rx", rx_valid, 1'b0);
      chk("mid_miso_idle", spi_miso, 1'b0);
      spi_en = 1'b0;
      repeat (SETTLE) @(posedge clk);
      #1 check_en = 1'b1;
      frame(8, {8'hC3, 32'h0}, 1'b0, got);
      chk("post_rst_rx_valid", rx_valid, 1'b1);
      chk("post_rst_rx_data", rx_data, 8'hC3);
      pop_rx();

      repeat (4) @(posedge clk);
      #1 check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
